am_mac_scheduler: RTL and testbench

//  Sequences the shared multiply-accumulate unit of the AM receiver between the cosine (C)
//  and sine (S) demodulation filters. On each input sample strobe it runs the TAPS-step MAC

---
 rtl/am_mac_scheduler.sv | 140 ++++++++++++++
 tb/tb_am_mac_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/am_mac_scheduler.sv
// Shared-MAC sequencer for the AM receiver: runs a cosine pass then a sine pass
// per sample strobe and captures each accumulator result with a one-cycle valid.
module am_mac_scheduler #(
    parameter int TAPS    = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] acc_in,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_sel,
    output logic [ADDR_W-1:0] tap_addr,
    output logic [DATA_W-1:0] ynC,
    output logic [DATA_W-1:0] ynS,
    output logic              ynC_valid,
    output logic              ynS_valid,
    output logic              busy,
    output logic              overrun
);

    // One counter serves both the tap index and the drain delay.
    localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int CNT_W = (ADDR_W > LAT_W) ? ADDR_W : LAT_W;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_LAT = CNT_W'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_C,
        S_MAC_C,
        S_DRAIN_C,
        S_CAPT_C,
        S_CLR_S,
        S_MAC_S,
        S_DRAIN_S,
        S_CAPT_S
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  r_ynC;
    logic [DATA_W-1:0]  r_ynS;
    logic               r_ynC_valid;
    logic               r_ynS_valid;
    logic               r_busy;
    logic               r_overrun;
    logic               w_capt_c;
    logic               w_capt_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_ynC       <= '0;
            r_ynS       <= '0;
            r_ynC_valid <= 1'b0;
            r_ynS_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_ynC_valid <= w_capt_c;
            r_ynS_valid <= w_capt_s;
            if (w_capt_c) r_ynC <= acc_in;
            if (w_capt_s) r_ynS <= acc_in;
            if (sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        mac_sel     = 1'b0;
        w_capt_c    = 1'b0;
        w_capt_s    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_tick) w_state_nxt = S_CLR_C;
            end
            S_CLR_C: begin
                mac_clr     = 1'b1;
                w_state_nxt = S_MAC_C;
            end
            S_MAC_C: begin
                mac_en = 1'b1;
                if (r_cnt == LAST_TAP) w_state_nxt = (MAC_LAT == 0) ? S_CAPT_C : S_DRAIN_C;
                else                   w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_DRAIN_C: begin
                if (r_cnt == LAST_LAT) w_state_nxt = S_CAPT_C;
                else                   w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_CAPT_C: begin
                w_capt_c    = 1'b1;
                w_state_nxt = S_CLR_S;
            end
            S_CLR_S: begin
                mac_sel     = 1'b1;
                mac_clr     = 1'b1;
                w_state_nxt = S_MAC_S;
            end
            S_MAC_S: begin
                mac_sel = 1'b1;
                mac_en  = 1'b1;
                if (r_cnt == LAST_TAP) w_state_nxt = (MAC_LAT == 0) ? S_CAPT_S : S_DRAIN_S;
                else                   w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_DRAIN_S: begin
                mac_sel = 1'b1;
                if (r_cnt == LAST_LAT) w_state_nxt = S_CAPT_S;
                else                   w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_CAPT_S: begin
                mac_sel     = 1'b1;
                w_capt_s    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign tap_addr  = mac_en ? r_cnt[ADDR_W-1:0] : '0;
    assign ynC       = r_ynC;
    assign ynS       = r_ynS;
    assign ynC_valid = r_ynC_valid;
    assign ynS_valid = r_ynS_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_am_mac_scheduler.sv
// Directed bench for am_mac_scheduler: default build driven by a behavioural MAC
// summing tap_addr, plus a TAPS=2 / MAC_LAT=0 build fed a constant -1 accumulator.
module tb_am_mac_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] acc_in;
    logic        mac_clr, mac_en, mac_sel;
    logic [3:0]  tap_addr;
    logic [31:0] ynC, ynS;
    logic        ynC_valid, ynS_valid, busy, overrun;

    logic        tick2 = 1'b0;
    logic [31:0] acc2 = 32'hFFFF_FFFF;
    logic        clr2, en2, sel2;
    logic [3:0]  addr2;
    logic [31:0] ynC2, ynS2;
    logic        vc2, vs2, busy2, ovr2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;
    int nvc, nvs, nen_c, nen_s, nbusy, nboth, tvc, tvs;

    always #5 clk = ~clk;

    am_mac_scheduler #(.TAPS(16), .ADDR_W(4), .DATA_W(32), .MAC_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .acc_in(acc_in),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_sel(mac_sel), .tap_addr(tap_addr),
        .ynC(ynC), .ynS(ynS), .ynC_valid(ynC_valid), .ynS_valid(ynS_valid),
        .busy(busy), .overrun(overrun)
    );

    am_mac_scheduler #(.TAPS(2), .ADDR_W(4), .DATA_W(32), .MAC_LAT(0)) u_small (
        .clk(clk), .rst(rst), .sample_tick(tick2), .acc_in(acc2),
        .mac_clr(clr2), .mac_en(en2), .mac_sel(sel2), .tap_addr(addr2),
        .ynC(ynC2), .ynS(ynS2), .ynC_valid(vc2), .ynS_valid(vs2),
        .busy(busy2), .overrun(ovr2)
    );

    // Behavioural MAC: accumulates the tap index, so a full pass yields sum(0..15)=120.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         acc_in <= '0;
        else if (mac_clr) acc_in <= '0;
        else if (mac_en)  acc_in <= acc_in + {28'd0, tap_addr};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        nvc = 0; nvs = 0; nen_c = 0; nen_s = 0; nbusy = 0; nboth = 0; tvc = -1; tvs = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ynC_valid) begin nvc++; if (tvc < 0) tvc = cyc; end
        if (ynS_valid) begin nvs++; if (tvs < 0) tvs = cyc; end
        if (mac_en && !mac_sel) nen_c++;
        if (mac_en && mac_sel)  nen_s++;
        if (busy) nbusy++;
        if (mac_en && mac_clr) nboth++;
    endtask

    task automatic start_pass();
        clear_counts();
        cyc = 0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    initial begin
        cyc = 0;
        clear_counts();

        // 1: reset held with activity on the inputs
        sample_tick = 1'b1;
        tick2 = 1'b1;
        repeat (3) step();
        check("rst_busy",   busy, 0);
        check("rst_outs",   {mac_clr, mac_en, mac_sel, tap_addr, ynC_valid, ynS_valid, overrun}, 0);
        check("rst_ync",    ynC, 0);
        check("rst_yns",    ynS, 0);
        sample_tick = 1'b0;
        tick2 = 1'b0;
        #2 rst = 1'b1;
        clear_counts();
        repeat (5) step();
        check("idle_busy",  nbusy, 0);
        check("idle_clr",   mac_clr, 0);

        // 2: single pass with default timing
        start_pass();
        check("c1_clr",   {mac_clr, mac_en, mac_sel}, 3'b100);
        while (cyc < 41) begin
            step();
            if (cyc == 2)  check("tap_first", tap_addr, 0);
            if (cyc == 17) check("tap_last", tap_addr, 15);
            if (cyc == 18) check("drain_c", {mac_clr, mac_en, tap_addr}, 0);
            if (cyc == 20) check("ync_before_capt", ynC, 0);
            if (cyc == 22) check("sel_s", mac_sel, 1);
        end
        check("t2_tvc",   tvc, 21);
        check("t2_tvs",   tvs, 41);
        check("t2_nvc",   nvc, 1);
        check("t2_nvs",   nvs, 1);
        check("t2_ync",   ynC, 120);
        check("t2_yns",   ynS, 120);
        check("t2_en_c",  nen_c, 16);
        check("t2_en_s",  nen_s, 16);
        check("t2_busy",  nbusy, 40);
        check("t2_idle",  {busy, mac_sel}, 0);
        check("t2_both",  nboth, 0);

        // 3: back-to-back ticks landing on IDLE re-entry
        clear_counts();
        for (int p = 0; p < 10; p++) begin
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            repeat (40) step();
        end
        check("t3_ovr",   overrun, 0);
        check("t3_nvc",   nvc, 10);
        check("t3_nvs",   nvs, 10);
        check("t3_eq",    ynC, ynS);
        check("t3_ync",   ynC, 120);

        // 4: tick while busy
        start_pass();
        repeat (9) step();
        check("t4_ovr_pre", overrun, 0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("t4_ovr_set", overrun, 1);
        while (cyc < 41) step();
        check("t4_tvc",  tvc, 21);
        check("t4_nvc",  nvc, 1);
        check("t4_nvs",  nvs, 1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("t4_accept", {busy, mac_clr}, 2'b11);
        repeat (40) step();
        check("t4_nvs2", nvs, 2);
        check("t4_ovr_hold", overrun, 1);

        // 5: reset inside MAC_S
        start_pass();
        while (cyc < 25) step();
        check("t5_in_mac_s", {mac_en, mac_sel}, 2'b11);
        rst = 1'b0;
        #1;
        check("t5_async_busy", busy, 0);
        check("t5_async_outs", {mac_en, mac_sel, tap_addr, overrun}, 0);
        check("t5_ync", ynC, 0);
        #2 rst = 1'b1;
        clear_counts();
        repeat (20) step();
        check("t5_no_vs", nvs, 0);
        check("t5_idle",  nbusy, 0);
        start_pass();
        while (cyc < 41) step();
        check("t5_tvs",   tvs, 41);
        check("t5_ync2",  ynC, 120);
        check("t5_yns2",  ynS, 120);

        // 6: TAPS=2, MAC_LAT=0 build with acc_in = -1
        tick2 = 1'b1;
        step();
        tick2 = 1'b0;
        check("t6_c1", {clr2, en2, sel2}, 3'b100);
        repeat (3) step();
        check("t6_vc_c4", vc2, 0);
        step();
        check("t6_vc_c5", vc2, 1);
        check("t6_ync",   ynC2, 32'hFFFF_FFFF);
        repeat (3) step();
        check("t6_vs_c8", vs2, 0);
        step();
        check("t6_vs_c9", vs2, 1);
        check("t6_yns",   ynS2, 32'hFFFF_FFFF);
        check("t6_idle",  busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
